// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: field-level requests in, packed machine words plus word addresses out through a 2-entry FIFO.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module inst_encoder #(
    parameter int          ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [31:0]       word;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } entry_t;

    state_t            state, state_next;
    entry_t            fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       enc_word;
    logic              is_shift;
    logic              push, pop, last_pop;
    logic              done_q;

    assign in_ready  = (state != DRAIN) && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && fifo_mem[rd_ptr].last;
    assign done      = done_q;

    // Head entry is masked while empty, so the storage itself needs no reset value.
    assign out_word  = out_valid ? fifo_mem[rd_ptr].word : 32'd0;
    assign out_addr  = out_valid ? fifo_mem[rd_ptr].addr : BASE;

    assign is_shift = (in_fmt == 3'd1) && (in_opcode == 7'b0010011) &&
                      ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        enc_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        case (in_fmt)
            3'd1: enc_word = is_shift
                      ? {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode}
                      : {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            3'd4: enc_word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage is deliberately left out of reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{word: enc_word, addr: addr_cnt, last: in_last};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_cnt <= BASE;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == DRAIN) && last_pop;
            if ((state == DRAIN) && last_pop) addr_cnt <= BASE;
            else if (push)                    addr_cnt <= addr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (push) state_next = in_last ? DRAIN : STREAM;
            STREAM:  if (push && in_last) state_next = DRAIN;
            DRAIN:   if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic signed [31:0] simm;
    logic               imm_viol;
    logic               err_clr;
    logic               err_q;
    logic [ADDR_W-1:0]  err_addr_q;

    assign simm    = in_imm;
    assign err_clr = push && (state == IDLE);

    always_comb begin
        imm_viol = 1'b0;
        case (in_fmt)
            3'd1:    imm_viol = is_shift ? (in_imm[31:5] != 27'd0)
                                         : ((simm < -32'sd2048) || (simm > 32'sd2047));
            3'd2:    imm_viol = (simm < -32'sd2048) || (simm > 32'sd2047);
            3'd3:    imm_viol = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
            3'd4:    imm_viol = (in_imm[11:0] != 12'd0);
            3'd5:    imm_viol = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
            default: ;
        endcase
    end

    // A new program starts clean, so its first violation re-captures the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (push) begin
            if (imm_viol) begin
                err_q <= 1'b1;
                if (!err_q || err_clr) err_addr_q <= addr_cnt;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: expected words/addresses queued at accept, compared at each output handshake.
// A second instance with ADDR_W=2 covers address wrap.
module tb_inst_encoder;

`ifdef ENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        out_valid, out_ready;
    logic [31:0] out_word;
    logic [11:0] out_addr;
    logic        done, err;
    logic [11:0] err_addr;

    logic        in2_valid, in2_ready, out2_valid, out2_ready;
    logic [31:0] out2_word;
    logic [1:0]  out2_addr, err_addr2;
    logic        done2, err2;

    inst_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
        .done(done), .err(err), .err_addr(err_addr)
    );

    inst_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in2_valid), .in_ready(in2_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out2_valid), .out_ready(out2_ready), .out_word(out2_word), .out_addr(out2_addr),
        .done(done2), .err(err2), .err_addr(err_addr2)
    );

    typedef struct {
        logic [31:0] word;
        logic [11:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors  = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_alt = alt;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_word, input logic [11:0] exp_addr);
        bit ok;
        ok = 1'b0;
        drive(fmt, op, f3, alt, rd, rs1, rs2, imm, last);
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sb.push_back('{exp_word, exp_addr});
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", {31'd0, ok}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < 20 && done_cnt == c0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("done_seen", done_cnt, c0 + 1);
        repeat (4) begin
            @(posedge clk);
            #2;
        end
        chk("done_once", done_cnt, c0 + 1);
    endtask

    // Output monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && out_valid && out_ready) begin
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("word", out_word, mon_e.word);
                chk("addr", {20'd0, out_addr}, {20'd0, mon_e.addr});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b1; out2_ready = 1'b1;
        drive(3'd0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_addr", err_addr, 0);
        rst = 1'b0;

        // One-word program: ADDI x1,x0,5, visible the cycle after accept
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 12'd0);
        chk("lat_valid", out_valid, 1);
        chk("lat_word", out_word, 32'h00500093);
        wait_done();

        // Four-instruction program at full throughput
        send(3'd0, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,      1'b0, 32'h402081B3, 12'd0);
        send(3'd2, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,      1'b0, 32'h0020A423, 12'd1);
        send(3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd4,    1'b0, 32'hFE000EE3, 12'd2);
        send(3'd5, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,   1'b1, 32'h001000EF, 12'd3);
        wait_done();

        // Backpressure: two accepts fill the FIFO, third waits; head held stable
        out_ready = 1'b0;
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, 12'd0);
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0, 32'h00700113, 12'd1);
        drive(3'd1, 7'h13, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, -32'sd1, 1'b1);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_ready", in_ready, 0);
            chk("stall_word", out_word, 32'h00500093);
            chk("stall_addr", out_addr, 0);
        end
        out_ready = 1'b1;
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, -32'sd1, 1'b1, 32'hFFF00193, 12'd2);
        wait_done();

        // Immediate range errors: out-of-range ADDI as second word, odd BEQ later
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1,    1'b0, 32'h00100093, 12'd0);
        chk("err_clean", err, 0);
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'h00000093, 12'd1);
        chk("err_set", err, RC);
        chk("err_addr_set", err_addr, RC ? 32'd1 : 32'd0);
        send(3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3,    1'b1, 32'h00000163, 12'd2);
        chk("err_addr_first", err_addr, RC ? 32'd1 : 32'd0);
        wait_done();
        chk("err_sticky", err, RC);
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,    1'b1, 32'h00500093, 12'd0);
        chk("err_cleared", err, 0);
        wait_done();

        // Address wrap on the ADDR_W=2 instance
        drive(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        in2_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] a2;
            a2 = 2'(i);
            @(negedge clk);
            chk("d2_ready", in2_ready, 1);
            @(posedge clk);
            #1;
            chk("d2_valid", out2_valid, 1);
            chk("d2_addr", out2_addr, a2);
            chk("d2_word", out2_word, 32'h00500093);
        end
        in2_valid = 1'b0;
        chk("d2_done", done2, 0);
        chk("d2_err", err2, 0);
        chk("d2_err_addr", err_addr2, 0);

        // Reset during DRAIN with two words buffered
        out_ready = 1'b0;
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, 12'd0);
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b1, 32'h00700113, 12'd1);
        chk("drain_ready", in_ready, 0);
        chk("drain_valid", out_valid, 1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", out_addr, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        begin
            int c0;
            c0 = done_cnt;
            repeat (4) begin
                @(posedge clk);
                #2;
            end
            chk("mid_rst_no_done", done_cnt, c0);
        end
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 12'd0);
        wait_done();

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder: accepts field-level instruction descriptions (format, opcode, funct3, register numbers, signed immediate) over a valid/ready handshake and emits packed 32-bit machine words with sequential instruction-memory word addresses. It sits between the test/boot sequencer and the instruction-memory write port, producing exactly the bit layouts the core's decoder unpacks. Output is buffered in a 2-entry FIFO. An FSM tracks program start, streaming and end-of-program drain.

## Interface
- ADDR_W, 12, instruction-memory word-address width
- BASE_ADDR, 0, first word address of each program
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J (6,7 treated as R)
- in_opcode  in  7  ir[6:0]
- in_funct3  in  3  ir[14:12]
- in_alt  in  1  sets ir[30] for R format and I-format shifts (SUB/SRA/SRAI)
- in_rd, in_rs1, in_rs2  in  5 each  register numbers
- in_imm  in  32  signed immediate (byte offset for B/J, full value for U)
- in_last  in  1  final instruction of program
- out_valid  out  1  word available
- out_ready  in  1  memory accepts word
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  word address
- done  out  1  one-cycle pulse after last word drained
- err  out  1  sticky immediate-range error
- err_addr  out  ADDR_W  address of first erroneous word

## Operation
- Encoding, ignoring fields not present in the format:
  - R: {0,alt,00000, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}; for shifts (op 0010011 with f3 001/101): {0,alt,00000, imm[4:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Address counter: starts at BASE_ADDR; increments on each accepted input; wraps mod 2^ADDR_W with no flag.
- Entry fields: word, addr, last. The FIFO pushes on in_valid && in_ready and pops on out_valid && out_ready. Push and pop may occur in the same cycle.
- in_ready = (state != DRAIN) && (fifo count < 2). When the FIFO is full, a simultaneous pop does not allow a same-cycle push.
- FSM:
  - IDLE: the first accept clears err, then moves to STREAM, or to DRAIN if in_last is set.
  - STREAM: an accept with in_last moves to DRAIN.
  - DRAIN: no accepts. When the last-flagged entry pops, assert done for one cycle, reset the counter to BASE_ADDR, and return to IDLE.
- An accept in IDLE with in_last set is a one-word program.

## Timing
- Reset values: in_ready=1 (IDLE, empty FIFO), out_valid=0, out_word=0, out_addr=BASE_ADDR, done=0, err=0, err_addr=0. State=IDLE, counter=BASE_ADDR.
- Reset mid-program discards FIFO contents and the FSM state in the same cycle. No done pulse is produced.
- Latency: an input accepted in cycle N makes out_valid high in cycle N+1 if the FIFO was empty.
- Throughput: 1 word/cycle while out_ready is held high.
- out_word and out_addr are held stable while out_valid && !out_ready.
- done asserts in the cycle after the popping handshake. in_ready returns high in the same cycle.

## Configuration
- ENC_RANGE_CHECK_EN defined: immediate range checking is enabled.
  - Violations are:
    - I/S outside -2048..2047.
    - Shift outside 0..31.
    - B outside -4096..4094 or odd.
    - J outside ±1 MiB or odd.
    - U with imm[11:0] != 0.
  - On a violation, set err (sticky) and capture err_addr on the first violation only.
  - The word is still emitted with the immediate truncated.
- ENC_RANGE_CHECK_EN undefined: no checking; err and err_addr are tied to 0; immediates are silently truncated.

## Test plan
- ADDI x1,x0,5 (fmt I, op 0010011, f3 0, rd 1, imm 5) -> out_word 0x00500093 at out_addr BASE_ADDR, one cycle after accept.
- Stream SUB x3,x1,x2 (alt=1), SW x2,8(x1), BEQ x0,x0,-4, JAL x1,2048 (last) with out_ready=1 -> 0x402081B3, 0x0020A423, 0xFE000EE3, 0x001000EF at addresses 0..3. done pulses once after the 4th pop; the counter returns to 0.
- Hold out_ready=0 and offer 3 inputs -> in_ready drops after 2 accepts. Release out_ready -> words emerge in order with none lost or duplicated.
- With ENC_RANGE_CHECK_EN, ADDI imm 4096 as the 2nd word -> err=1, err_addr=1, out_word imm field 0. A later BEQ imm 3 does not change err_addr. The next program's first accept clears err. Without the macro -> err stays 0.
- ADDR_W=2: accept 5 words -> addresses 0,1,2,3,0.
- Assert rst with 2 words buffered during DRAIN -> next cycle out_valid=0, in_ready=1, done=0, out_addr=BASE_ADDR.
